// File: rtl/mem_port_arbiter.sv
// Shares one memory between the CPU control path and a debug/loader port.
// Each access holds the memory for MEM_LAT cycles, then pulses the owner's ack for one cycle.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall,
  output logic              busy
);

  // state  | meaning
  // IDLE   | no access in flight; arbitrate and latch the winner
  // ACCESS | memory driven from the latched request for MEM_LAT cycles
  // DONE   | owner's ack pulses for one cycle
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam int LAT_W = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);
  localparam int STK_W = $clog2(STARVE_MAX + 1);

  state_t             state, state_nxt;
  logic               owner_dbg;
  logic               we_lat;
  logic [LAT_W-1:0]   lat_cnt;
  logic [STK_W-1:0]   streak;
  logic               any_req;
  logic               grant_dbg;
  logic               lat_done;

  assign any_req   = cpu_req | dbg_req;
  // CPU wins ties until it has starved the debug port STARVE_MAX times in a row
  assign grant_dbg = dbg_req & (~cpu_req | (streak == STK_W'(STARVE_MAX)));
  assign lat_done  = (state == ACCESS) && (lat_cnt == LAT_W'(MEM_LAT - 1));
  assign stall     = cpu_req & ~cpu_ack;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ACCESS;
      ACCESS:  if (lat_done) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner_dbg <= 1'b0;
      we_lat    <= 1'b0;
      lat_cnt   <= '0;
      streak    <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_ack   <= 1'b0;
      dbg_ack   <= 1'b0;
      cpu_rdata <= '0;
      dbg_rdata <= '0;
    end else begin
      cpu_ack <= 1'b0;
      dbg_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (!dbg_req) streak <= '0;
          if (any_req) begin
            owner_dbg <= grant_dbg;
            we_lat    <= grant_dbg ? dbg_we : cpu_we;
            mem_en    <= 1'b1;
            mem_we    <= grant_dbg ? dbg_we : cpu_we;
            mem_addr  <= grant_dbg ? dbg_addr : cpu_addr;
            mem_wdata <= grant_dbg ? dbg_wdata : cpu_wdata;
            lat_cnt   <= '0;
            if (grant_dbg)
              streak <= '0;
            else if (dbg_req && (streak != STK_W'(STARVE_MAX)))
              streak <= streak + STK_W'(1);
          end
        end
        ACCESS: begin
          lat_cnt <= lat_cnt + LAT_W'(1);
          mem_we  <= 1'b0;
          if (lat_done) begin
            mem_en    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if (!we_lat) begin
              if (owner_dbg) dbg_rdata <= mem_rdata;
              else           cpu_rdata <= mem_rdata;
            end
            cpu_ack <= ~owner_dbg;
            dbg_ack <= owner_dbg;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset abort, read/write latency, address hold,
// tie-break and starvation limit, all checked against hand-computed cycle expectations.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata, mem_rdata;
  logic        cpu_ack, dbg_ack, mem_en, mem_we, stall, busy;
  logic [31:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall(stall), .busy(busy)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  int ack_cnt;
  int n_ack;
  int we_cnt;
  logic drop;
  logic [31:0] owners [6];
  int when [6];

  initial begin
    rst_n = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
    mem_rdata = '0;
    cyc(); cyc();
    smp();
    check_val("rst_mem_en", {31'b0, mem_en}, 32'd0);
    check_val("rst_busy", {31'b0, busy}, 32'd0);
    check_val("rst_cpu_rdata", cpu_rdata, 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Reset during ACCESS aborts the read
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10; mem_rdata = 32'h0BAD_0BAD;
    cyc();
    rst_n = 1'b0;
    smp();
    check_val("t1_access_en", {31'b0, mem_en}, 32'd1);
    cyc();
    rst_n = 1'b1; cpu_req = 0;
    smp();
    check_val("t1_mem_en", {31'b0, mem_en}, 32'd0);
    check_val("t1_mem_addr", mem_addr, 32'd0);
    check_val("t1_busy", {31'b0, busy}, 32'd0);
    check_val("t1_stall", {31'b0, stall}, 32'd0);
    check_val("t1_cpu_rdata", cpu_rdata, 32'd0);
    ack_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (cpu_ack) ack_cnt++;
      cyc(); smp();
    end
    check_val("t1_no_ack", ack_cnt, 32'd0);

    // CPU read: ACCESS cycles 1-2, ack cycle 3
    cyc();
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10; mem_rdata = 32'hDEAD_BEEF;
    smp();
    check_val("t2_c0_stall", {31'b0, stall}, 32'd1);
    check_val("t2_c0_en", {31'b0, mem_en}, 32'd0);
    cyc(); smp();
    check_val("t2_c1_en", {31'b0, mem_en}, 32'd1);
    check_val("t2_c1_addr", mem_addr, 32'h10);
    check_val("t2_c1_we", {31'b0, mem_we}, 32'd0);
    check_val("t2_c1_stall", {31'b0, stall}, 32'd1);
    cyc(); smp();
    check_val("t2_c2_en", {31'b0, mem_en}, 32'd1);
    check_val("t2_c2_ack", {31'b0, cpu_ack}, 32'd0);
    check_val("t2_c2_stall", {31'b0, stall}, 32'd1);
    cyc(); smp();
    check_val("t2_c3_ack", {31'b0, cpu_ack}, 32'd1);
    check_val("t2_c3_rdata", cpu_rdata, 32'hDEAD_BEEF);
    check_val("t2_c3_en", {31'b0, mem_en}, 32'd0);
    check_val("t2_c3_stall", {31'b0, stall}, 32'd0);
    check_val("t2_c3_dbg_ack", {31'b0, dbg_ack}, 32'd0);
    cyc();
    cpu_req = 0;
    smp();
    check_val("t2_c4_ack", {31'b0, cpu_ack}, 32'd0);
    check_val("t2_c4_busy", {31'b0, busy}, 32'd0);

    // CPU write: one mem_we cycle, rdata untouched
    cyc();
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h20; cpu_wdata = 32'h1234; mem_rdata = 32'h5555_5555;
    we_cnt = 0;
    smp();
    if (mem_we) we_cnt++;
    cyc(); smp();
    if (mem_we) we_cnt++;
    check_val("t3_c1_we", {31'b0, mem_we}, 32'd1);
    check_val("t3_c1_addr", mem_addr, 32'h20);
    check_val("t3_c1_wdata", mem_wdata, 32'h1234);
    cyc(); smp();
    if (mem_we) we_cnt++;
    check_val("t3_c2_en", {31'b0, mem_en}, 32'd1);
    cyc(); smp();
    if (mem_we) we_cnt++;
    check_val("t3_c3_ack", {31'b0, cpu_ack}, 32'd1);
    check_val("t3_c3_rdata", cpu_rdata, 32'hDEAD_BEEF);
    cyc();
    cpu_req = 0; cpu_we = 0;
    smp();
    if (mem_we) we_cnt++;
    check_val("t3_we_cycles", we_cnt, 32'd1);

    // Requester address change during ACCESS is ignored
    cyc();
    cpu_req = 1; cpu_addr = 32'h10; mem_rdata = 32'hCAFE_F00D;
    cyc();
    cpu_addr = 32'h44;
    smp();
    check_val("t6_c1_addr", mem_addr, 32'h10);
    cyc(); smp();
    check_val("t6_c2_addr", mem_addr, 32'h10);
    cyc(); smp();
    check_val("t6_c3_ack", {31'b0, cpu_ack}, 32'd1);
    check_val("t6_c3_rdata", cpu_rdata, 32'hCAFE_F00D);
    check_val("t6_c3_addr", mem_addr, 32'd0);
    cyc();
    cpu_req = 0;

    // Simultaneous requests: CPU first, then debug four cycles later
    cyc();
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h30; mem_rdata = 32'h1111_1111;
    dbg_req = 1; dbg_we = 0; dbg_addr = 32'h80;
    cyc(); smp();
    check_val("t4_c1_addr", mem_addr, 32'h30);
    cyc(); cyc(); smp();
    check_val("t4_c3_cpu_ack", {31'b0, cpu_ack}, 32'd1);
    check_val("t4_c3_dbg_ack", {31'b0, dbg_ack}, 32'd0);
    check_val("t4_c3_cpu_rdata", cpu_rdata, 32'h1111_1111);
    cyc();
    cpu_req = 0;
    smp();
    check_val("t4_c4_busy", {31'b0, busy}, 32'd0);
    cyc();
    mem_rdata = 32'hA5A5_0001;
    smp();
    check_val("t4_c5_addr", mem_addr, 32'h80);
    check_val("t4_c5_en", {31'b0, mem_en}, 32'd1);
    cyc(); cyc(); smp();
    check_val("t4_c7_dbg_ack", {31'b0, dbg_ack}, 32'd1);
    check_val("t4_c7_cpu_ack", {31'b0, cpu_ack}, 32'd0);
    check_val("t4_c7_dbg_rdata", dbg_rdata, 32'hA5A5_0001);
    check_val("t4_c7_cpu_rdata", cpu_rdata, 32'h1111_1111);
    cyc();
    dbg_req = 0;
    smp();
    check_val("t4_c8_dbg_ack", {31'b0, dbg_ack}, 32'd0);

    // Both held: four CPU grants, then debug, then CPU again
    cyc();
    cpu_req = 1; dbg_req = 1; mem_rdata = 32'h7777_0000;
    n_ack = 0; drop = 0;
    for (int c = 0; c < 80 && n_ack < 6; c++) begin
      smp();
      if (cpu_ack || dbg_ack) begin
        owners[n_ack] = {31'b0, dbg_ack};
        when[n_ack] = c;
        n_ack++;
        if (dbg_ack) drop = 1;
      end
      cyc();
      if (drop) begin
        dbg_req = 0;
        drop = 0;
      end
    end
    cpu_req = 0;
    check_val("t5_ack_count", n_ack, 32'd6);
    for (int i = 0; i < n_ack; i++) begin
      check_val($sformatf("t5_owner%0d", i), owners[i], (i == 4) ? 32'd1 : 32'd0);
      check_val($sformatf("t5_cycle%0d", i), when[i], 3 + 4 * i);
    end
    for (int i = 0; i < 6; i++) cyc();
    smp();
    check_val("t5_final_busy", {31'b0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
